mem_arbiter: RTL and testbench

Two-master arbiter that shares the single unified instruction/data memory of the multicycle ARM core with a second bus master (boot loader / debug DMA). It sits between the `arm` top level (master 0), the loader (master 1) and the memory. It grants one owner at a time with round-robin fairness and optional ownership lock. Starvation under lock is bounded by a hold counter. Read data is captured into per-master response registers.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one unified memory port between the ARM core (M0) and the
// loader/debug DMA (M1): round-robin per transfer, optional lock bounded by MAX_HOLD.
module mem_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] adr0,
    input  logic [31:0] adr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last;
    logic        w_last_next;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_next;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        w_xfer0;
    logic        w_xfer1;
    logic        w_other_req;
    logic        w_hold_ok;

    assign w_xfer0     = (r_state == OWN0) && req0;
    assign w_xfer1     = (r_state == OWN1) && req1;
    assign w_other_req = (r_state == OWN0) ? req1 : req0;
    // Widened by one bit so hold_cnt+1 cannot wrap when MAX_HOLD is 255.
    assign w_hold_ok   = ({1'b0, r_hold_cnt} + 9'd1) < 9'(MAX_HOLD);

    always_comb begin
        // NOTE: each combinational output is given a default first so no path can infer a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req0 && req1) w_next_state = r_last ? OWN0 : OWN1;
                else if (req0)    w_next_state = OWN0;
                else if (req1)    w_next_state = OWN1;
            end
            OWN0: begin
                if (!req0)                                 w_next_state = req1 ? OWN1 : IDLE;
                else if (req1 && (!lock0 || !w_hold_ok))   w_next_state = OWN1;
            end
            OWN1: begin
                if (!req1)                                 w_next_state = req0 ? OWN0 : IDLE;
                else if (req0 && (!lock1 || !w_hold_ok))   w_next_state = OWN0;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_last_next = r_last;
        if (r_state == OWN0 && w_next_state != OWN0)      w_last_next = 1'b0;
        else if (r_state == OWN1 && w_next_state != OWN1) w_last_next = 1'b1;
    end

    // The streak only grows while the same owner keeps the bus against a waiting rival.
    always_comb begin
        w_hold_next = '0;
        if (r_state != IDLE && w_next_state == r_state && w_other_req)
            w_hold_next = r_hold_cnt + 8'd1;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        case (r_state)
            OWN0: begin
                mem_we    = req0 && we0;
                mem_adr   = adr0;
                mem_wdata = wdata0;
            end
            OWN1: begin
                mem_we    = req1 && we1;
                mem_adr   = adr1;
                mem_wdata = wdata1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_next_state;
            r_last     <= w_last_next;
            r_hold_cnt <= w_hold_next;
            r_rvalid0  <= w_xfer0 && !we0;
            r_rvalid1  <= w_xfer1 && !we1;
            if (w_xfer0 && !we0) r_rdata0 <= mem_rdata;
            if (w_xfer1 && !we1) r_rdata1 <= mem_rdata;
        end
    end

    assign gnt0    = (r_state == OWN0);
    assign gnt1    = (r_state == OWN1);
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural owner/streak model checked every cycle, directed
// scenarios with hand-computed grant patterns, then randomized two-master traffic.
module tb_mem_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [31:0] adr   [2];
    logic [31:0] wdata [2];
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_adr, mem_wdata, mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req[0]),
        .req1     (req[1]),
        .we0      (we[0]),
        .we1      (we[1]),
        .lock0    (lock[0]),
        .lock1    (lock[1]),
        .adr0     (adr[0]),
        .adr1     (adr[1]),
        .wdata0   (wdata[0]),
        .wdata1   (wdata[1]),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] pattern(input logic [5:0] i);
        return {16'hC0DE, 10'd0, i};
    endfunction

    // Memory seen by the DUT: combinational read, write at the edge.
    logic [31:0] env_mem [64];
    bit          env_init = 1'b0;
    assign mem_rdata = env_mem[mem_adr[7:2]];
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 64; i++) env_mem[i[5:0]] <= pattern(i[5:0]);
            env_init <= 1'b1;
        end else if (mem_we) begin
            env_mem[mem_adr[7:2]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who owned it last, length of the contested streak.
    bit          m_busy, m_who, m_last, nb, nw, k;
    int          m_hold;
    logic [1:0]  m_rvalid, m_xfer;
    logic [31:0] m_rdata [2];
    logic [31:0] ref_mem [64];
    logic        e_we;
    logic [31:0] e_adr, e_wd;

    initial begin : model
        for (int i = 0; i < 64; i++) ref_mem[i[5:0]] = pattern(i[5:0]);
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_busy = 1'b0; m_who = 1'b0; m_last = 1'b1; m_hold = 0;
                m_rvalid = '0; m_xfer = '0; m_rdata[0] = '0; m_rdata[1] = '0;
                check("reset_ctl", 128'({gnt0, gnt1, rvalid0, rvalid1, mem_we}), 128'(0));
                check("reset_bus", 128'({mem_adr, mem_wdata}), 128'(0));
                check("reset_rdata", 128'({rdata0, rdata1}), 128'(0));
            end else begin
                e_we = 1'b0; e_adr = '0; e_wd = '0;
                if (m_busy) begin
                    e_we = req[m_who] && we[m_who]; e_adr = adr[m_who]; e_wd = wdata[m_who];
                end
                check("gnt", 128'({gnt1, gnt0}), 128'({m_busy && m_who, m_busy && !m_who}));
                check("gnt_onehot", 128'(gnt0 && gnt1), 128'(0));
                check("mem_bus", 128'({mem_we, mem_adr, mem_wdata}), 128'({e_we, e_adr, e_wd}));
                check("rvalid", 128'({rvalid1, rvalid0}), 128'(m_rvalid));
                check("rdata0", 128'(rdata0), 128'(m_rdata[0]));
                check("rdata1", 128'(rdata1), 128'(m_rdata[1]));

                m_xfer = '0; m_rvalid = '0;
                if (m_busy && req[m_who]) begin
                    m_xfer[m_who] = 1'b1;
                    if (we[m_who]) ref_mem[adr[m_who][7:2]] = wdata[m_who];
                    else begin
                        m_rvalid[m_who] = 1'b1;
                        m_rdata[m_who]  = ref_mem[adr[m_who][7:2]];
                    end
                end
                nb = 1'b0; nw = 1'b0;
                if (!m_busy) begin
                    nb = req[0] || req[1];
                    nw = (req[0] && req[1]) ? !m_last : req[1];
                end else begin
                    k = m_who;
                    if (!req[k])       begin nb = req[!k]; nw = !k; end
                    else if (!req[!k]) begin nb = 1'b1;    nw = k;  end
                    else begin
                        nb = 1'b1;
                        nw = (lock[k] && (m_hold + 1 < MAX_HOLD)) ? k : !k;
                    end
                end
                if (m_busy && nb && nw == m_who && req[!m_who]) m_hold++;
                else m_hold = 0;
                if (m_busy && !(nb && nw == m_who)) m_last = m_who;
                m_busy = nb; m_who = nw;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_fields(input bit i);
        we[i]    = 1'($urandom);
        lock[i]  = 1'($urandom);
        adr[i]   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        wdata[i] = $urandom;
    endtask

    task automatic random_master(input bit i);
        if (req[i] && m_xfer[i]) begin
            if ($urandom_range(0, 9) < 7) new_fields(i);
            else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            new_fields(i);
        end
    endtask

    int s_left [2];
    int s_start[2];
    bit s_we   [2];
    bit s_lock [2];

    task automatic stream_master(input bit i, input int c);
        if (req[i] && m_xfer[i]) begin
            s_left[i]--;
            if (s_left[i] == 0) req[i] = 1'b0;
            else begin
                adr[i]   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                wdata[i] = $urandom;
            end
        end else if (!req[i] && c == s_start[i] && s_left[i] > 0) begin
            req[i]   = 1'b1;
            we[i]    = s_we[i];
            lock[i]  = s_lock[i];
            adr[i]   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            wdata[i] = $urandom;
        end
    endtask

    // Each master starts at its own cycle and streams a fixed number of transfers.
    task automatic run_streams(input int st0, input int n0, input bit w0, input bit l0,
                               input int st1, input int n1, input bit w1, input bit l1,
                               input int ncyc, output logic [15:0] h0, output logic [15:0] h1,
                               output int rv0, output int rv1);
        s_start[0] = st0; s_left[0] = n0; s_we[0] = w0; s_lock[0] = l0;
        s_start[1] = st1; s_left[1] = n1; s_we[1] = w1; s_lock[1] = l1;
        h0 = '0; h1 = '0; rv0 = 0; rv1 = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            stream_master(1'b0, c);
            stream_master(1'b1, c);
            #1;
            if (gnt0) h0 |= 16'(1) << c;
            if (gnt1) h1 |= 16'(1) << c;
            if (rvalid0) rv0++;
            if (rvalid1) rv1++;
        end
    endtask

    task automatic pulse_reset();
        tick();
        reset = 1'b0;
        req   = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [15:0] h0, h1;
    int          rv0, rv1;

    initial begin : stimulus
        reset = 1'b0;
        req = '0; we = '0; lock = '0;
        adr[0] = '0; adr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Reset held with random inputs, then idle with no requests.
        for (int c = 0; c < 4; c++) begin
            tick();
            req = 2'($urandom); we = 2'($urandom); lock = 2'($urandom);
            adr[0] = $urandom; adr[1] = $urandom; wdata[0] = $urandom; wdata[1] = $urandom;
            #1;
            check("rst_outputs", 128'({gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_adr}), 128'(0));
        end
        req = '0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("idle_quiet", 128'({gnt0, gnt1, mem_we}), 128'(0));
        end

        // M0 writes 0xDEADBEEF to 0x40 then reads it back.
        req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b0; adr[0] = 32'h40; wdata[0] = 32'hDEADBEEF;
        tick(); #1;
        check("wr_gnt0", 128'({gnt0, mem_we, mem_adr}), 128'({1'b1, 1'b1, 32'h40}));
        tick();
        we[0] = 1'b0;
        #1;
        check("rd_no_we", 128'({gnt0, mem_we}), 128'({1'b1, 1'b0}));
        tick();
        req[0] = 1'b0;
        #1;
        check("rd_rvalid0", 128'({rvalid0, rdata0}), 128'({1'b1, 32'hDEADBEEF}));
        tick();
        check("rd_pulse_once", 128'({rvalid0, rdata0}), 128'({1'b0, 32'hDEADBEEF}));

        // Fair interleave of four reads each after reset.
        pulse_reset();
        run_streams(0, 4, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0, 12, h0, h1, rv0, rv1);
        check("rr_gnt0_hist", 128'(h0), 128'(16'h00AA));
        check("rr_gnt1_hist", 128'(h1), 128'(16'h0354));
        check("rr_overlap", 128'(h0 & h1), 128'(0));
        check("rr_rvalid_cnt", 128'({rv0, rv1}), 128'({32'd4, 32'd4}));

        // M1 locked writes with M0 waiting: MAX_HOLD transfers then M0, then back to M1.
        run_streams(1, 1, 1'b0, 1'b0, 0, 6, 1'b1, 1'b1, 12, h0, h1, rv0, rv1);
        check("lock_gnt0_hist", 128'(h0), 128'(16'h0020));
        check("lock_gnt1_hist", 128'(h1), 128'(16'h01DE));
        check("lock_rvalid_cnt", 128'({rv0, rv1}), 128'({32'd1, 32'd0}));

        // M0 drops while M1 waits; then nobody requests.
        run_streams(0, 2, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 8, h0, h1, rv0, rv1);
        check("drop_gnt0_hist", 128'(h0), 128'(16'h000E));
        check("drop_gnt1_hist", 128'(h1), 128'(16'h0030));
        check("drop_idle_bus", 128'({gnt0, gnt1, mem_we, mem_adr}), 128'(0));

        // Asynchronous reset in the middle of an M1 write.
        tick();
        req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b0; adr[1] = 32'h80; wdata[1] = 32'h12345678;
        tick(); #1;
        check("cut_pre", 128'({gnt1, mem_we}), 128'({1'b1, 1'b1}));
        #1;
        reset = 1'b0;
        #1;
        check("cut_now", 128'({gnt1, mem_we}), 128'(0));
        req[1] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("cut_no_regrant", 128'({gnt1, rvalid1}), 128'(0));
        end
        req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h80;
        tick(); #1;
        check("cut_regrant", 128'(gnt1), 128'(1));
        tick();
        req[1] = 1'b0;
        #1;
        check("cut_write_lost", 128'({rvalid1, rdata1}), 128'({1'b1, pattern(6'd32)}));

        // Randomized traffic with rare asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            random_master(1'b0);
            random_master(1'b1);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                reset = 1'b0;
                req   = '0;
                tick();
                reset = 1'b1;
            end
        end
        req = '0;
        for (int c = 0; c < 4; c++) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
